// File: rtl/wb_intercon_nslave_if.sv
// ---------------------------------------------------------------------------
// wb_intercon_nslave_if
// Bundles every bus signal of the single-master / N-slave Wishbone classic
// interconnect. The wbm_* group faces the upstream master and the wbs_* group
// faces the peripherals (packed, slave k occupies slice k).
//
// Modports:
//   master - the interconnect's view: it receives the master request and the
//            slave responses, and drives the master response and slave requests.
//   slave  - the complementary environment view (bus master plus peripherals).
// ---------------------------------------------------------------------------
interface wb_intercon_nslave_if #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0]            wbm_adr_i;
    logic [DATA_W-1:0]            wbm_dat_i;
    logic [SEL_W-1:0]             wbm_sel_i;
    logic                         wbm_we_i;
    logic                         wbm_cyc_i;
    logic                         wbm_stb_i;
    logic [DATA_W-1:0]            wbm_dat_o;
    logic                         wbm_ack_o;
    logic                         wbm_err_o;

    logic [NUM_SLAVES*ADDR_W-1:0] wbs_adr_o;
    logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_o;
    logic [NUM_SLAVES*SEL_W-1:0]  wbs_sel_o;
    logic [NUM_SLAVES-1:0]        wbs_we_o;
    logic [NUM_SLAVES-1:0]        wbs_cyc_o;
    logic [NUM_SLAVES-1:0]        wbs_stb_o;
    logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_i;
    logic [NUM_SLAVES-1:0]        wbs_ack_i;
    logic [NUM_SLAVES-1:0]        wbs_err_i;

    modport master (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i
    );

    modport slave (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i
    );
endinterface

// File: rtl/wb_intercon_nslave.sv
// ---------------------------------------------------------------------------
// wb_intercon_nslave
// Parametrised single-master, N-slave Wishbone classic interconnect with a
// registered address decode, bus error on unmapped addresses, a watchdog on
// stalled slaves and a sticky fault-address/fault-code register.
//
// Ports:
//   wb_clk_i     - clock
//   wb_rst_i     - asynchronous active-high reset
//   bus          - wb_intercon_nslave_if.master: master request/response and
//                  the packed per-slave request/response buses
//   fault_clr_i  - clears fault_code_o (fault_addr_o is kept)
//   fault_addr_o - address of the most recent errored transfer
//   fault_code_o - 01 decode miss, 10 slave err, 11 timeout, 00 none/cleared
// ---------------------------------------------------------------------------
module wb_intercon_nslave #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {NUM_SLAVES{{ADDR_W{1'b0}}}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{{ADDR_W{1'b0}}}},
    parameter int TIMEOUT    = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_intercon_nslave_if.master bus,
    input  logic                 fault_clr_i,
    output logic [ADDR_W-1:0]    fault_addr_o,
    output logic [1:0]           fault_code_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DECODE, BUSY, RESP} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     lat_adr;
    logic [DATA_W-1:0]     lat_dat;
    logic [SEL_W-1:0]      lat_sel;
    logic                  lat_we;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic [NUM_SLAVES-1:0] hit_oh;
    logic                  hit_any;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W-1:0]     rd_data;
    logic                  ack_q;
    logic                  err_q;
    logic                  sel_ack;
    logic                  sel_err;

    // Address decode of the latched request. Scanning upward and stopping at
    // the first match gives overlapping windows to the lowest slave index.
    always_comb begin
        hit_oh  = '0;
        hit_any = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!hit_any &&
                ((lat_adr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W])) begin
                hit_oh[k] = 1'b1;
                hit_any   = 1'b1;
            end
        end
    end

    // Response path: only the selected slave's data/ack/err are looked at, so
    // a stray ack from an unselected (stb=0) slave has no effect.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_oh[k]) begin
                rd_data = rd_data | bus.wbs_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ack = |(bus.wbs_ack_i & sel_oh);
    assign sel_err = |(bus.wbs_err_i & sel_oh);

    // Slave fan-out: every slave sees the latched request fields, but cyc/stb
    // reach only the selected slave and only while in BUSY. Gating by the state
    // register makes an asynchronous reset drop them immediately.
    always_comb begin
        for (int k = 0; k < NUM_SLAVES; k++) begin
            bus.wbs_adr_o[k*ADDR_W +: ADDR_W] = lat_adr;
            bus.wbs_dat_o[k*DATA_W +: DATA_W] = lat_dat;
            bus.wbs_sel_o[k*SEL_W +: SEL_W]   = lat_sel;
        end
        bus.wbs_we_o  = {NUM_SLAVES{lat_we}};
        bus.wbs_cyc_o = (state == BUSY) ? sel_oh : '0;
        bus.wbs_stb_o = (state == BUSY) ? sel_oh : '0;
    end

    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_ack_o = ack_q;
    assign bus.wbm_err_o = err_q;

    // Main controller. ack/err are registered one-cycle pulses that only ever
    // appear in RESP. An error in the same cycle as fault_clr_i overrides the
    // clear because its assignment comes later in the block.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            lat_adr      <= '0;
            lat_dat      <= '0;
            lat_sel      <= '0;
            lat_we       <= 1'b0;
            sel_oh       <= '0;
            tmo_cnt      <= '0;
            dat_q        <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            fault_addr_o <= '0;
            fault_code_o <= 2'b00;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (fault_clr_i) begin
                fault_code_o <= 2'b00;
            end
            case (state)
                IDLE: begin
                    if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                        lat_adr <= bus.wbm_adr_i;
                        lat_dat <= bus.wbm_dat_i;
                        lat_sel <= bus.wbm_sel_i;
                        lat_we  <= bus.wbm_we_i;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (hit_any) begin
                        sel_oh  <= hit_oh;
                        tmo_cnt <= '0;
                        state   <= BUSY;
                    end else begin
                        err_q        <= 1'b1;
                        fault_addr_o <= lat_adr;
                        fault_code_o <= 2'b01;
                        state        <= RESP;
                    end
                end
                BUSY: begin
                    if (!bus.wbm_cyc_i) begin
                        state <= IDLE;
                    end else if (sel_err) begin
                        err_q        <= 1'b1;
                        fault_addr_o <= lat_adr;
                        fault_code_o <= 2'b10;
                        state        <= RESP;
                    end else if (sel_ack) begin
                        if (!lat_we) begin
                            dat_q <= rd_data;
                        end
                        ack_q <= 1'b1;
                        state <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q        <= 1'b1;
                        fault_addr_o <= lat_adr;
                        fault_code_o <= 2'b11;
                        state        <= RESP;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
